// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared state encoding, parameter defaults and address-fault helper
//          for data_mem_responder (fault helper used with DMEM_ERR_CHECK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Misaligned or beyond the end of the word array.
  function automatic logic addr_faults(input logic [31:0] addr,
                                       input int unsigned depth_words);
    logic [33:0] limit;
    limit = 34'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_array.sv
// ============================================================================
// Module : dmem_array
// Brief  : Single-port synchronous word RAM with registered read data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register returns 0 whenever no read is issued, so store and
  // faulting responses naturally carry zero data.
  always_comb begin
    rdata_d = re ? mem_q[addr] : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : Fixed-latency LDR/STR data-memory responder with pipeline stall and
//          kill handling. Optional DMEM_ERR_CHECK_EN enables address faults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_w_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        kill,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        commit;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        fault;

  // With zero wait cycles the commit edge is the acceptance edge, so the
  // array must see the live request rather than the latched copy.
  assign acc_we    = (state_q == ST_IDLE) ? req_w_en  : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !kill;
        if (req_valid && !kill) begin
          stall   = 1'b1;
          we_d    = req_w_en;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (kill) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = !kill;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic err_d, err_q;

  assign fault = addr_faults(acc_addr, DEPTH_WORDS);
  assign err_d = commit && fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_addr_bits;

  assign fault            = 1'b0;
  assign resp_err         = 1'b0;
  assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && acc_we && !fault),
    .re    (commit && !acc_we && !fault),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (resp_rdata)
  );

endmodule

`default_nettype wire
